// File: rtl/pp_pipeline_accel_norm_u8x2.sv
// Two-lane u8 normaliser between stream FIFOs: (px - mean) * scale >>> SHIFT, saturated to s8.
// Optional PP_NORM_BYPASS_EN adds a latched 'bypass' input that passes words through unchanged.
module pp_pipeline_accel_norm_u8x2 #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned SHIFT      = 7,
    parameter int unsigned CNT_W      = 24
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    input  logic [CNT_W-1:0]      num_words,
    input  logic [LANE_W-1:0]     mean0,
    input  logic [LANE_W-1:0]     mean1,
    input  logic [LANE_W-1:0]     scale,
`ifdef PP_NORM_BYPASS_EN
    input  logic                  bypass,
`endif
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty_n,
    output logic                  in_read,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full_n,
    output logic                  out_write
);

    localparam int unsigned NL    = DATA_WIDTH / LANE_W;
    localparam int unsigned PW    = 2 * LANE_W + 2;
    localparam int          SAT_I = (1 << (LANE_W - 1)) - 1;
    localparam logic signed [PW-1:0] SAT_MAX = PW'(SAT_I);
    localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [CNT_W-1:0]             r_num;
    logic [NL-1:0][LANE_W-1:0]    r_mean;
    logic [LANE_W-1:0]            r_scale;
    logic [CNT_W-1:0]             r_rd_cnt;
    logic [CNT_W-1:0]             r_wr_cnt;
    logic [CNT_W-1:0]             w_rd_nxt;
    logic [CNT_W-1:0]             w_wr_nxt;
    logic                         r_s1_valid;
    logic                         r_s2_valid;
    logic [NL-1:0][PW-1:0]        r_s1_prod;
    logic [NL-1:0][LANE_W:0]      w_diff;
    logic [NL-1:0][PW-1:0]        w_prod;
    logic [DATA_WIDTH-1:0]        w_norm;
    logic [DATA_WIDTH-1:0]        w_s2_word;
    logic [DATA_WIDTH-1:0]        r_out_din;
    logic                         w_adv;
    logic                         w_start;

    function automatic logic [LANE_W-1:0] f_sat(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] sh;
        sh = p >>> SHIFT;
        if (sh > SAT_MAX)
            f_sat = SAT_MAX[LANE_W-1:0];
        else if (sh < SAT_MIN)
            f_sat = SAT_MIN[LANE_W-1:0];
        else
            f_sat = sh[LANE_W-1:0];
    endfunction

    assign w_adv     = !(r_s2_valid && !out_full_n);
    assign w_start   = (r_state == IDLE) && ap_start;
    assign in_read   = (r_state == RUN) && (r_rd_cnt < r_num) && in_empty_n && w_adv;
    assign out_write = r_s2_valid && out_full_n;
    assign out_din   = r_out_din;
    assign w_rd_nxt  = r_rd_cnt + CNT_W'(in_read);
    assign w_wr_nxt  = r_wr_cnt + CNT_W'(out_write);

    always_comb begin
        w_diff = '0;
        w_prod = '0;
        w_norm = '0;
        for (int unsigned l = 0; l < NL; l++) begin
            w_diff[l] = $signed({1'b0, in_dout[l*LANE_W +: LANE_W]}) - $signed({1'b0, r_mean[l]});
            w_prod[l] = $signed(w_diff[l]) * $signed({1'b0, r_scale});
            w_norm[l*LANE_W +: LANE_W] = f_sat($signed(r_s1_prod[l]));
        end
    end

`ifdef PP_NORM_BYPASS_EN
    logic                  r_bypass;
    logic [DATA_WIDTH-1:0] r_s1_raw;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_bypass <= 1'b0;
            r_s1_raw <= '0;
        end else begin
            if (w_start)
                r_bypass <= bypass;
            if (w_adv && in_read)
                r_s1_raw <= in_dout;
        end
    end

    assign w_s2_word = r_bypass ? r_s1_raw : w_norm;
`else
    assign w_s2_word = w_norm;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_num    <= '0;
            r_mean   <= '0;
            r_scale  <= '0;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else if (w_start) begin
            r_num    <= num_words;
            r_mean   <= {mean1, mean0};
            r_scale  <= scale;
            r_rd_cnt <= '0;
            r_wr_cnt <= '0;
        end else begin
            r_rd_cnt <= w_rd_nxt;
            r_wr_cnt <= w_wr_nxt;
        end
    end

    // Stall freezes both stages together so bubbles keep their slots.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s1_prod  <= '0;
            r_out_din  <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_read;
            r_s2_valid <= r_s1_valid;
            if (in_read)
                r_s1_prod <= w_prod;
            if (r_s1_valid)
                r_out_din <= w_s2_word;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // Transitions look at the post-update counts so DONE follows the final write by one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (ap_start) w_next = (num_words == '0) ? DONE : RUN;
            RUN:     if (w_rd_nxt == r_num) w_next = DRAIN;
            DRAIN:   if (w_wr_nxt == r_num) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        ap_idle  = 1'b0;
        if (r_state == DONE) begin
            ap_done  = 1'b1;
            ap_ready = 1'b1;
        end
        if (r_state == IDLE)
            ap_idle = 1'b1;
    end

endmodule
